// File: rtl/pwm_peripheral.sv
// Sixteen-output PWM peripheral: each output is forced low, static high, or driven by a
// shared 8-bit PWM waveform whose duty cycle is double-buffered at the period boundary.
module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0]  prescaler_r;
   logic [7:0]  pwm_cnt_r;
   logic [7:0]  duty_shadow_r;
   logic        tick_s;
   logic        wrap_s;
   logic        pwm_sig_s;
   logic [15:0] en_out_s;
   logic [15:0] en_pwm_s;
   logic [15:0] out_next_s;

   // Count-step strobe, period boundary, PWM compare and next output value.
   always_comb begin
      tick_s   = (prescaler_r == DIV_LAST);
      wrap_s   = tick_s && (pwm_cnt_r == 8'hFF);
      en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      // Full scale means truly always-on, not 255/256.
      if (duty_shadow_r == 8'hFF) begin
         pwm_sig_s = 1'b1;
      end else begin
         pwm_sig_s = (pwm_cnt_r < duty_shadow_r);
      end
      out_next_s = en_out_s & ((en_pwm_s & {16{pwm_sig_s}}) | ~en_pwm_s);
   end

   // Prescaler, PWM counter, duty shadow and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_r   <= 8'h00;
         pwm_cnt_r     <= 8'h00;
         duty_shadow_r <= 8'h00;
         out           <= 16'h0000;
         period_start  <= 1'b0;
      end else begin
         if (tick_s) begin
            prescaler_r <= 8'h00;
            pwm_cnt_r   <= pwm_cnt_r + 8'h01;
         end else begin
            prescaler_r <= prescaler_r + 8'h01;
            pwm_cnt_r   <= pwm_cnt_r;
         end
         // The shadow only moves on the same edge that wraps the counter to 0.
         if (wrap_s) begin
            duty_shadow_r <= pwm_duty_cycle;
         end else begin
            duty_shadow_r <= duty_shadow_r;
         end
         out          <= out_next_s;
         period_start <= wrap_s;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: directed scenarios plus random register writes,
// compared every cycle against an arithmetic model of time-since-reset.
module tb_pwm_peripheral;

   localparam int CLK_DIV = 13;
   localparam int PERIOD  = 256 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  en_out_lo = 8'h00;
   logic [7:0]  en_out_hi = 8'h00;
   logic [7:0]  en_pwm_lo = 8'h00;
   logic [7:0]  en_pwm_hi = 8'h00;
   logic [7:0]  duty = 8'h00;
   logic [15:0] out;
   logic        period_start;

   int          checks = 0;
   int          failures = 0;
   int          hi0 = 0;
   int          ps_cnt = 0;

   // Reference model state: clocks elapsed since reset release, plus duty shadow.
   int unsigned k = 0;
   logic [7:0]  m_shadow = 8'h00;
   logic [15:0] m_out = 16'h0000;
   logic        m_ps = 1'b0;

   pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_out_lo),
      .en_reg_out_15_8 (en_out_hi),
      .en_reg_pwm_7_0  (en_pwm_lo),
      .en_reg_pwm_15_8 (en_pwm_hi),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of one rising edge, using the inputs that were stable before it.
   task automatic model_edge();
      int unsigned cnt;
      logic        sig;
      logic [15:0] eo;
      logic [15:0] ep;
      if (!rst_n) begin
         k        = 0;
         m_shadow = 8'h00;
         m_out    = 16'h0000;
         m_ps     = 1'b0;
      end else begin
         cnt = (k / CLK_DIV) % 256;
         sig = (m_shadow == 8'hFF) || (cnt < 32'(m_shadow));
         eo  = {en_out_hi, en_out_lo};
         ep  = {en_pwm_hi, en_pwm_lo};
         for (int i = 0; i < 16; i++) begin
            m_out[i] = eo[i] && (!ep[i] || sig);
         end
         m_ps = ((k % PERIOD) == PERIOD - 1);
         if (m_ps) m_shadow = duty;
         k++;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk("out", 32'(out), 32'(m_out));
         chk("period_start", 32'(period_start), 32'(m_ps));
         if (out[0]) hi0++;
         if (period_start) ps_cnt++;
      end
   endtask

   // Advance until the model has just passed a period boundary.
   task automatic sync_period();
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!m_ps && n < PERIOD + 10);
      chk("sync_found", 32'(m_ps), 32'd1);
   endtask

   initial begin
      int n;
      step(3);
      chk("reset_out", 32'(out), 32'h0000);
      chk("reset_ps", 32'(period_start), 32'd0);
      rst_n = 1'b1;

      // Static-high output and period_start cadence.
      en_out_lo = 8'h01;
      step(1);
      chk("static_out", 32'(out), 32'h0001);
      ps_cnt = 0;
      step(2 * PERIOD);
      chk("ps_count_2_periods", 32'(ps_cnt), 32'd2);

      // 50% duty: rising edge right after period_start, 1664 high clocks.
      en_pwm_lo = 8'h01;
      duty = 8'h80;
      sync_period();
      hi0 = 0;
      step(1);
      chk("pwm_rise_after_ps", 32'(out[0]), 32'd1);
      step(PERIOD - 1);
      chk("hi_duty_80", 32'(hi0), 32'd1664);

      // 0% and 100% extremes.
      duty = 8'h00;
      sync_period();
      hi0 = 0;
      step(PERIOD);
      chk("hi_duty_00", 32'(hi0), 32'd0);
      duty = 8'hFF;
      sync_period();
      hi0 = 0;
      step(2 * PERIOD);
      chk("hi_duty_ff_2_periods", 32'(hi0), 32'(2 * PERIOD));

      // Mid-period duty change is deferred to the next period.
      duty = 8'h40;
      sync_period();
      hi0 = 0;
      step(8'h20 * CLK_DIV);
      duty = 8'hC0;
      step(PERIOD - 8'h20 * CLK_DIV);
      chk("hi_current_40", 32'(hi0), 32'd832);
      hi0 = 0;
      step(PERIOD);
      chk("hi_next_c0", 32'(hi0), 32'd2496);

      // Upper byte: odd bits PWM, even bits static high.
      en_out_hi = 8'hFF;
      en_pwm_hi = 8'hAA;
      duty = 8'h80;
      sync_period();
      step(100);
      chk("upper_pwm_high_phase", 32'(out[15:8]), 32'hFF);
      step(1600);
      chk("upper_pwm_low_phase", 32'(out[15:8]), 32'h55);
      en_out_hi = 8'h00;
      step(1);
      chk("upper_disabled", 32'(out[15:8]), 32'h00);

      // Random register traffic against the model.
      for (int r = 0; r < 20; r++) begin
         en_out_lo = 8'($urandom);
         en_out_hi = 8'($urandom);
         en_pwm_lo = 8'($urandom);
         en_pwm_hi = 8'($urandom);
         duty      = 8'($urandom);
         step(int'($urandom_range(1, 400)));
      end

      // Reset mid-period at pwm_cnt = 0x77.
      en_out_lo = 8'hFF;
      en_pwm_lo = 8'h00;
      n = 0;
      while ((((k / CLK_DIV) % 256) != 32'h77) && n < PERIOD + 10) begin
         step(1);
         n++;
      end
      chk("reached_cnt_77", (k / CLK_DIV) % 256, 32'h77);
      rst_n = 1'b0;
      #1;
      chk("async_reset_out", 32'(out), 32'h0000);
      chk("async_reset_ps", 32'(period_start), 32'd0);
      step(3);
      rst_n = 1'b1;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!period_start && n < PERIOD + 10);
      chk("first_ps_after_reset", 32'(n), 32'(PERIOD));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
